vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 15, video RAM address width.
REQ-002 SHALL have parameter DATA_W, 8, video RAM data width.
REQ-003 SHALL have parameter MAX_HOLD, 4, max consecutive locked grants to one requester (1..15).
REQ-004 SHALL have port clk  input  1  the single system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports cpu_req / blt_req  input  1  access request from CPU / blitter.
REQ-007 SHALL have ports cpu_lock / blt_lock  input  1  request to keep ownership next cycle.
REQ-008 SHALL have ports cpu_add / blt_add  input  ADDR_W  request address.
REQ-009 SHALL have ports cpu_we / blt_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have ports cpu_wdata / blt_wdata  input  DATA_W  write data.
REQ-011 SHALL have ports cpu_ack / blt_ack  output  1  access issued to RAM this cycle.
REQ-012 SHALL have ports cpu_rvalid / blt_rvalid  output  1  read data valid.
REQ-013 SHALL have port rdata  output  DATA_W  read data, shared by both requesters.
REQ-014 SHALL have ports ram_add  output  ADDR_W, ram_wdata  output  DATA_W, ram_we  output  1  to video RAM CPU-side port.
REQ-015 SHALL have port ram_rdata  input  DATA_W  video RAM read data, one-cycle synchronous latency.

Function
REQ-016 SHALL issue at most one RAM access per cycle; ack asserted for the granted requester in the same cycle its request is driven onto ram_*.
REQ-017 SHALL hold a requester's add/we/wdata stable from req rise until ack; arbiter samples them only in the ack cycle.
REQ-018 SHALL implement states IDLE, OWN_CPU, OWN_BLT; state is registered, grant/mux decode is combinational from state and req.
REQ-019 SHALL, in IDLE or with the owner not locking, grant by the arbitration policy (REQ-031) when any req is high.
REQ-020 SHALL move to OWN_x after a grant with x_lock=1, and keep granting x while x_req=1 and x_lock=1, incrementing a 4-bit hold counter.
REQ-021 SHALL release ownership when hold counter reaches MAX_HOLD and the other requester has req=1, granting the other requester on that cycle; hold counter reloads to 1 on every ownership change.
REQ-022 SHALL return to IDLE when the owner drops req or lock and no grant occurs that cycle.
REQ-023 SHALL drive ram_we = granted x_we & ack; ram_we = 0 with no grant; ram_add/ram_wdata don't-care when no grant.
REQ-024 SHALL assert x_rvalid exactly one cycle after an ack with x_we=0, with rdata = ram_rdata that cycle; writes produce no rvalid.
REQ-025 SHALL allow back-to-back reads from either requester with rvalid tagged to the correct requester.
REQ-026 SHALL, when both req=1 in the same cycle with neither owning, grant exactly one and leave the other pending without ack.

Reset
REQ-027 SHALL, on rst=1, immediately force state IDLE, hold counter 0, both ack 0, both rvalid 0, ram_we 0, rdata 0.
REQ-028 SHALL set the round-robin pointer to favour CPU first after reset.
REQ-029 SHALL discard a read in flight at reset: no rvalid after rst deasserts.
REQ-030 SHALL accept requests on the first rising edge after rst deasserts.

Configuration
REQ-031 SHALL support macro VRAM_ARB_RR_EN: defined = round-robin, pointer toggles to the loser after every contested grant; undefined = fixed priority, CPU always wins contested IDLE grants (lock/MAX_HOLD rules still apply).

Structure
REQ-032 SHALL place state enum (IDLE, OWN_CPU, OWN_BLT), requester ID constants and default widths in shared package vram_pkg.
REQ-033 SHALL be a single module with no sub-modules; sits between XERA4_CPU/blitter and the Video_RAM CPU port.

Verification
REQ-034 SHALL verify: cpu_req only, read 0x1234 (RAM holds 0x5A) -> cpu_ack same cycle, cpu_rvalid next cycle, rdata 0x5A.
REQ-035 SHALL verify: both req, write, in IDLE with VRAM_ARB_RR_EN -> CPU ack cycle 1, BLT ack cycle 2; without macro repeated contention -> CPU wins every IDLE cycle.
REQ-036 SHALL verify: blt_lock held, MAX_HOLD=4, cpu_req continuously -> exactly 4 consecutive blt_ack, then cpu_ack.
REQ-037 SHALL verify: alternating CPU read/BLT read back-to-back -> rvalid toggles requester each cycle, data matches addresses.
REQ-038 SHALL verify: rst asserted mid-read (cycle of ack) -> no rvalid, ram_we 0, state IDLE, first post-reset contested grant to CPU.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types, requester IDs and default widths for the video RAM arbiter.
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W   = 15;
  localparam int unsigned VRAM_DATA_W   = 8;
  localparam int unsigned VRAM_MAX_HOLD = 4;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_BLT = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_BLT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vram_arbiter.sv
// Arbitrates CPU and blitter accesses onto the CPU-side port of video RAM.
// Define VRAM_ARB_RR_EN for round-robin contention; otherwise the CPU has fixed priority.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W   = VRAM_ADDR_W,
  parameter int unsigned DATA_W   = VRAM_DATA_W,
  parameter int unsigned MAX_HOLD = VRAM_MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_add,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              blt_req,
  input  logic              blt_lock,
  input  logic [ADDR_W-1:0] blt_add,
  input  logic              blt_we,
  input  logic [DATA_W-1:0] blt_wdata,
  output logic              cpu_ack,
  output logic              blt_ack,
  output logic              cpu_rvalid,
  output logic              blt_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_add,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] HoldMax = 4'(MAX_HOLD);

  arb_state_e state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_who_q, rd_who_d;
  logic       gnt_cpu, gnt_blt, use_policy;

`ifdef VRAM_ARB_RR_EN
  // 1 = blitter wins the next contested grant.
  logic rr_q, rr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  always_comb begin
    gnt_cpu    = 1'b0;
    gnt_blt    = 1'b0;
    use_policy = 1'b1;
`ifdef VRAM_ARB_RR_EN
    rr_d       = rr_q;
`endif
    // A locking owner keeps the port until its hold budget runs out against a waiting rival.
    case (state_q)
      OWN_CPU: begin
        if (cpu_req && cpu_lock) begin
          use_policy = 1'b0;
          if (blt_req && (hold_q >= HoldMax)) gnt_blt = 1'b1;
          else                                gnt_cpu = 1'b1;
        end
      end
      OWN_BLT: begin
        if (blt_req && blt_lock) begin
          use_policy = 1'b0;
          if (cpu_req && (hold_q >= HoldMax)) gnt_cpu = 1'b1;
          else                                gnt_blt = 1'b1;
        end
      end
      default: ;
    endcase

    if (use_policy) begin
      if (cpu_req && blt_req) begin
`ifdef VRAM_ARB_RR_EN
        gnt_blt = rr_q;
        gnt_cpu = !rr_q;
        rr_d    = !rr_q;
`else
        gnt_cpu = 1'b1;
`endif
      end else begin
        gnt_cpu = cpu_req;
        gnt_blt = blt_req;
      end
    end

    if (rst) begin
      gnt_cpu = 1'b0;
      gnt_blt = 1'b0;
    end
  end

  always_comb begin
    state_d = IDLE;
    hold_d  = 4'd0;
    if (gnt_cpu) state_d = cpu_lock ? OWN_CPU : IDLE;
    if (gnt_blt) state_d = blt_lock ? OWN_BLT : IDLE;

    if ((gnt_cpu && (state_q == OWN_CPU)) || (gnt_blt && (state_q == OWN_BLT))) begin
      hold_d = (hold_q == 4'hF) ? hold_q : hold_q + 4'd1;
    end else if (gnt_cpu || gnt_blt) begin
      hold_d = 4'd1;
    end

    rd_pend_d = (gnt_cpu && !cpu_we) || (gnt_blt && !blt_we);
    rd_who_d  = gnt_blt ? REQ_BLT : REQ_CPU;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= 4'd0;
      rd_pend_q <= 1'b0;
      rd_who_q  <= REQ_CPU;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rd_pend_q <= rd_pend_d;
      rd_who_q  <= rd_who_d;
    end
  end

  assign cpu_ack    = gnt_cpu;
  assign blt_ack    = gnt_blt;
  assign ram_add    = gnt_blt ? blt_add : cpu_add;
  assign ram_wdata  = gnt_blt ? blt_wdata : cpu_wdata;
  assign ram_we     = (gnt_cpu && cpu_we) || (gnt_blt && blt_we);

  assign cpu_rvalid = rd_pend_q && (rd_who_q == REQ_CPU);
  assign blt_rvalid = rd_pend_q && (rd_who_q == REQ_BLT);
  assign rdata      = rd_pend_q ? ram_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised bench for vram_arbiter against a cycle-level behavioural model of the arbitration rules.
module tb_vram_arbiter;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 8;
  localparam int unsigned MH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req, cpu_lock, cpu_we, blt_req, blt_lock, blt_we;
  logic [AW-1:0] cpu_add, blt_add, ram_add;
  logic [DW-1:0] cpu_wdata, blt_wdata, ram_wdata, ram_rdata, rdata;
  logic          cpu_ack, blt_ack, cpu_rvalid, blt_rvalid, ram_we;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];

  int n_pass  = 0;
  int n_total = 0;

  // Model: owner 0 = none, 1 = CPU, 2 = blitter.
  int         m_owner      = 0;
  int         m_count      = 0;
  bit         m_favour_blt = 1'b0;
  bit         m_rd_valid   = 1'b0;
  int         m_rd_who     = 0;
  logic [7:0] m_rd_data    = 8'h00;
  int         e_g          = 0;
  bit         e_contested  = 1'b0;
  bit         rr_en;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_lock   (cpu_lock),
    .cpu_add    (cpu_add),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .blt_req    (blt_req),
    .blt_lock   (blt_lock),
    .blt_add    (blt_add),
    .blt_we     (blt_we),
    .blt_wdata  (blt_wdata),
    .cpu_ack    (cpu_ack),
    .blt_ack    (blt_ack),
    .cpu_rvalid (cpu_rvalid),
    .blt_rvalid (blt_rvalid),
    .rdata      (rdata),
    .ram_add    (ram_add),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Video RAM with one-cycle synchronous read.
  always @(posedge clk) begin
    if (ram_we) mem[ram_add] <= ram_wdata;
    ram_rdata <= mem[ram_add];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Called 1 time unit after a rising edge; evaluates the model and compares mid-cycle.
  task automatic step();
    int   g;
    bit   cont;
    bit   cpu_keep, blt_keep;
    logic exp_we;
    #3;
    g        = 0;
    cont     = 1'b0;
    cpu_keep = (m_owner == 1) && cpu_req && cpu_lock;
    blt_keep = (m_owner == 2) && blt_req && blt_lock;
    if (cpu_keep)                 g = (blt_req && m_count >= int'(MH)) ? 2 : 1;
    else if (blt_keep)            g = (cpu_req && m_count >= int'(MH)) ? 1 : 2;
    else if (cpu_req && blt_req) begin
      cont = 1'b1;
      g    = (rr_en && m_favour_blt) ? 2 : 1;
    end
    else if (cpu_req)             g = 1;
    else if (blt_req)             g = 2;
    e_g         = g;
    e_contested = cont;

    exp_we = (g == 1) ? cpu_we : (g == 2) ? blt_we : 1'b0;
    check("cpu_ack", 32'(cpu_ack), 32'(g == 1));
    check("blt_ack", 32'(blt_ack), 32'(g == 2));
    check("ram_we", 32'(ram_we), 32'(exp_we));
    if (g != 0) begin
      check("ram_add", 32'(ram_add), 32'((g == 1) ? cpu_add : blt_add));
      if (exp_we) check("ram_wdata", 32'(ram_wdata), 32'((g == 1) ? cpu_wdata : blt_wdata));
    end
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rd_valid && m_rd_who == 1));
    check("blt_rvalid", 32'(blt_rvalid), 32'(m_rd_valid && m_rd_who == 2));
    if (m_rd_valid) check("rdata", 32'(rdata), 32'(m_rd_data));
  endtask

  // Commits the model's view of this cycle and advances to just after the next rising edge.
  task automatic adv();
    logic          we, lk;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    m_rd_valid = 1'b0;
    if (e_g != 0) begin
      we = (e_g == 1) ? cpu_we    : blt_we;
      lk = (e_g == 1) ? cpu_lock  : blt_lock;
      a  = (e_g == 1) ? cpu_add   : blt_add;
      d  = (e_g == 1) ? cpu_wdata : blt_wdata;
      if (we) exp_mem[a] = d;
      else begin
        m_rd_valid = 1'b1;
        m_rd_who   = e_g;
        m_rd_data  = exp_mem[a];
      end
      m_count = (e_g == m_owner) ? ((m_count < 15) ? m_count + 1 : 15) : 1;
      m_owner = lk ? e_g : 0;
    end else begin
      m_owner = 0;
      m_count = 0;
    end
    if (e_contested) m_favour_blt = (e_g == 1);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_owner      = 0;
    m_count      = 0;
    m_favour_blt = 1'b0;
    m_rd_valid   = 1'b0;
    e_g          = 0;
    e_contested  = 1'b0;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_lock = 1'b0; cpu_we = 1'b0; cpu_add = '0; cpu_wdata = '0;
    blt_req = 1'b0; blt_lock = 1'b0; blt_we = 1'b0; blt_add = '0; blt_wdata = '0;
  endtask

  // A requester keeps its transaction stable until acked; lock may change every cycle.
  task automatic rand_inputs();
    if (!cpu_req || e_g == 1) begin
      cpu_req   = ($urandom_range(0, 99) < 70);
      cpu_add   = AW'($urandom_range(0, 31));
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_wdata = DW'($urandom);
    end
    if (!blt_req || e_g == 2) begin
      blt_req   = ($urandom_range(0, 99) < 70);
      blt_add   = AW'($urandom_range(0, 31));
      blt_we    = 1'($urandom_range(0, 1));
      blt_wdata = DW'($urandom);
    end
    cpu_lock = ($urandom_range(0, 99) < 60);
    blt_lock = ($urandom_range(0, 99) < 60);
  endtask

  initial begin
`ifdef VRAM_ARB_RR_EN
    rr_en = 1'b1;
`else
    rr_en = 1'b0;
`endif
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = DW'(i) ^ 8'hC3;
      exp_mem[i] = DW'(i) ^ 8'hC3;
    end
    mem[15'h1234]     = 8'h5A;
    exp_mem[15'h1234] = 8'h5A;

    // Reset with both requesting: nothing may be issued.
    idle_inputs();
    cpu_req = 1'b1; blt_req = 1'b1; cpu_we = 1'b1; blt_we = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("reset cpu_ack", 32'(cpu_ack), 32'd0);
    check("reset blt_ack", 32'(blt_ack), 32'd0);
    check("reset cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("reset blt_rvalid", 32'(blt_rvalid), 32'd0);
    check("reset ram_we", 32'(ram_we), 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b0;
    model_reset();

    // Single CPU read.
    cpu_req = 1'b1; cpu_add = 15'h1234;
    step();
    check("rd cpu_ack", 32'(cpu_ack), 32'd1);
    check("rd ram_add", 32'(ram_add), 32'h1234);
    adv();
    cpu_req = 1'b0;
    step();
    check("rd cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("rd rdata", 32'(rdata), 32'h5A);
    adv();

    // Contested writes from IDLE.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_add = 15'h0100; cpu_wdata = 8'h11;
    blt_req = 1'b1; blt_we = 1'b1; blt_add = 15'h0200; blt_wdata = 8'h22;
`ifdef VRAM_ARB_RR_EN
    step();
    check("rr c1 cpu_ack", 32'(cpu_ack), 32'd1);
    check("rr c1 blt_ack", 32'(blt_ack), 32'd0);
    adv();
    cpu_add = 15'h0101;
    step();
    check("rr c2 cpu_ack", 32'(cpu_ack), 32'd0);
    check("rr c2 blt_ack", 32'(blt_ack), 32'd1);
    adv();
`else
    for (int i = 0; i < 3; i++) begin
      step();
      check("fp cpu_ack", 32'(cpu_ack), 32'd1);
      check("fp blt_ack", 32'(blt_ack), 32'd0);
      adv();
      cpu_add = cpu_add + 15'd1;
    end
    cpu_req = 1'b0;
    step();
    check("fp blt served", 32'(blt_ack), 32'd1);
    adv();
`endif
    idle_inputs();

    // Blitter locks; CPU waits exactly MAX_HOLD grants.
    blt_req = 1'b1; blt_lock = 1'b1; blt_we = 1'b1; blt_add = 15'h0300; blt_wdata = 8'h33;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_add = 15'h0310; cpu_wdata = 8'h44;
      end
      step();
      check("hold blt_ack", 32'(blt_ack), 32'(i < 4));
      check("hold cpu_ack", 32'(cpu_ack), 32'(i == 4));
      adv();
      blt_add = blt_add + 15'd1;
    end
    idle_inputs();
    step();
    adv();

    // Alternating back-to-back reads.
    cpu_req = 1'b1; cpu_add = 15'h0010;
    step();
    check("alt cpu_ack", 32'(cpu_ack), 32'd1);
    adv();
    cpu_req = 1'b0; blt_req = 1'b1; blt_add = 15'h0020;
    step();
    check("alt blt_ack", 32'(blt_ack), 32'd1);
    check("alt cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("alt rdata 10", 32'(rdata), 32'hD3);
    adv();
    blt_req = 1'b0; cpu_req = 1'b1; cpu_add = 15'h0030;
    step();
    check("alt blt_rvalid", 32'(blt_rvalid), 32'd1);
    check("alt rdata 20", 32'(rdata), 32'hE3);
    adv();
    cpu_req = 1'b0;
    step();
    check("alt cpu_rvalid 2", 32'(cpu_rvalid), 32'd1);
    check("alt rdata 30", 32'(rdata), 32'hF3);
    adv();

    // One contested grant moves the round-robin pointer away from the CPU.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_add = 15'h0400;
    blt_req = 1'b1; blt_we = 1'b1; blt_add = 15'h0500;
    step();
    adv();
    idle_inputs();

    // Reset lands while a read is in flight.
    cpu_req = 1'b1; cpu_add = 15'h0040;
    step();
    adv();
    rst = 1'b1;
    #1;
    check("rst cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst ram_we", 32'(ram_we), 32'd0);
    check("rst rdata", 32'(rdata), 32'd0);
    check("rst cpu_ack", 32'(cpu_ack), 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    rst = 1'b0;
    model_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_add = 15'h0600;
    blt_req = 1'b1; blt_we = 1'b1; blt_add = 15'h0700;
    step();
    check("post-rst cpu_ack", 32'(cpu_ack), 32'd1);
    check("post-rst blt_ack", 32'(blt_ack), 32'd0);
    check("post-rst no rvalid", 32'(cpu_rvalid), 32'd0);
    adv();
    cpu_req = 1'b0;
    step();
    check("post-rst blt next", 32'(blt_ack), 32'd1);
    adv();
    idle_inputs();

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
